button_conditioner: RTL and testbench

- Front-end stage for a raw pushbutton input.
- Chain: 2-flop synchronizer, then a debounce state machine, then edge/auto-repeat pulse generation.
- Output pulses drive the increment input of downstream event counters (8-bit mod-256 counters) directly; no external one-shot flops are needed.
- One instance per button. All outputs are registered.

---
 rtl/button_conditioner.sv | 150 +++++++++++++++
 tb/tb_button_conditioner.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Pushbutton front end: 2-flop synchronizer, debounce FSM, then press/release/auto-repeat pulses.
// Every output is a flop, so the pulses can drive counter increment inputs directly.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic repeat_en,
    output logic debounced,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic action_pulse
);

    localparam int MAX_DH     = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYCLES = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HIGH,
        HELD,
        WAIT_LOW
    } state_t;

    state_t        state_q, state_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic          rep_phase_q, rep_phase_d;
    logic          debounced_q, debounced_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          repeat_q, repeat_d;
    logic          action_q, action_d;
    logic [CW-1:0] hcnt_last;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
        s1_d        = btn;
        s2_d        = s1_q;
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        hcnt_d      = hcnt_q;
        rep_phase_d = rep_phase_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        repeat_d    = 1'b0;
        // First repeat waits HOLD_CYCLES, later ones REPEAT_CYCLES.
        hcnt_last   = rep_phase_q ? REP_LAST : HOLD_LAST;

        unique case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = WAIT_HIGH;
                    dcnt_d  = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s2_q) begin
                    state_d = IDLE;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d     = HELD;
                    press_d     = 1'b1;
                    hcnt_d      = '0;
                    rep_phase_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!s2_q) begin
                    state_d = WAIT_LOW;
                    dcnt_d  = '0;
                end else if (!repeat_en) begin
                    hcnt_d      = '0;
                    rep_phase_d = 1'b0;
                end else if (hcnt_q == hcnt_last) begin
                    repeat_d    = 1'b1;
                    hcnt_d      = '0;
                    rep_phase_d = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            WAIT_LOW: begin
                // hcnt stays frozen here so a bounce back to HELD resumes the repeat timing.
                if (s2_q) begin
                    state_d = HELD;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d     = IDLE;
                    release_d   = 1'b1;
                    hcnt_d      = '0;
                    rep_phase_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        debounced_d = (state_d == HELD) || (state_d == WAIT_LOW);
        action_d    = press_d | repeat_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            dcnt_q      <= '0;
            hcnt_q      <= '0;
            rep_phase_q <= 1'b0;
            debounced_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            repeat_q    <= 1'b0;
            action_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            dcnt_q      <= dcnt_d;
            hcnt_q      <= hcnt_d;
            rep_phase_q <= rep_phase_d;
            debounced_q <= debounced_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
            action_q    <= action_d;
        end
    end

    assign debounced     = debounced_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;
    assign action_pulse  = action_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: vector table, hand-written corner sequences and
// randomized stimulus checked against a run-length / countdown reference model.
module tb_button_conditioner;

    localparam int D = 4;
    localparam int H = 10;
    localparam int R = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn = 1'b0;
    logic repeat_en = 1'b0;
    logic debounced, press_pulse, release_pulse, repeat_pulse, action_pulse;
    logic [4:0] outs;

    assign outs = {debounced, press_pulse, release_pulse, repeat_pulse, action_pulse};

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn),
        .repeat_en    (repeat_en),
        .debounced    (debounced),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse),
        .action_pulse (action_pulse)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    // Reference model: 2-sample delay line, run length of samples disagreeing with the
    // filtered level, and a countdown to the next auto-repeat.
    logic m_s1, m_s2, m_prev_vis, m_deb;
    int   m_run, m_remain;
    logic [4:0] m_out;

    // Observations of the DUT pulses
    int   press_cnt, release_cnt, press_at, release_at, deb_rise_at, deb_fall_at;
    int   rep_q[$];
    logic [7:0] evt_cnt;
    logic last_deb;

    typedef struct packed {
        logic       btn;
        logic       en;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_prev_vis = 1'b0; m_deb = 1'b0;
        m_run = 0; m_remain = 0; m_out = '0;
    endtask

    task automatic model_step(input logic b, input logic e);
        logic vis, deb_before, pr, rl, rp;
        vis = m_s2;
        deb_before = m_deb;
        pr = 1'b0; rl = 1'b0; rp = 1'b0;
        // Level accepted after D+1 consecutive synchronized samples at the new level.
        if (vis != m_deb) begin
            m_run++;
            if (m_run == D + 1) begin
                m_deb = vis;
                m_run = 0;
                pr = vis;
                rl = !vis;
            end
        end else begin
            m_run = 0;
        end
        // Held and staying held: count down to the next repeat.
        if (deb_before && vis && m_prev_vis) begin
            if (!e) begin
                m_remain = H;
            end else begin
                m_remain--;
                if (m_remain == 0) begin
                    rp = 1'b1;
                    m_remain = R;
                end
            end
        end
        if (pr) m_remain = H;
        m_prev_vis = vis;
        m_s2 = m_s1;
        m_s1 = b;
        m_out = {m_deb, pr, rl, rp, pr | rp};
    endtask

    task automatic clear_obs();
        press_cnt = 0; release_cnt = 0; press_at = -1; release_at = -1;
        deb_rise_at = -1; deb_fall_at = -1;
        rep_q.delete();
    endtask

    task automatic cyc(input logic b, input logic e);
        btn = b;
        repeat_en = e;
        @(posedge clk);
        #1;
        cyc_n++;
        model_step(b, e);
        check("model", 32'(outs), 32'(m_out));
        if (press_pulse) begin press_cnt++; press_at = cyc_n; end
        if (release_pulse) begin release_cnt++; release_at = cyc_n; end
        if (repeat_pulse) rep_q.push_back(cyc_n);
        if (action_pulse) evt_cnt = evt_cnt + 8'd1;
        if (debounced && !last_deb) deb_rise_at = cyc_n;
        if (!debounced && last_deb) deb_fall_at = cyc_n;
        last_deb = debounced;
    endtask

    task automatic run(input logic b, input logic e, input int n);
        for (int i = 0; i < n; i++) cyc(b, e);
    endtask

    // Asserts reset between clock edges, checks the outputs clear at once, then releases.
    task automatic do_reset(input int hold);
        reset = 1'b1;
        #1;
        check("reset_async", 32'(outs), 32'h0);
        model_reset();
        last_deb = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            cyc_n++;
            check("reset_hold", 32'(outs), 32'h0);
        end
        reset = 1'b0;
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_n);
        $fatal(1);
    end

    initial begin
        int   start, base, p2, e0, got;
        int   exp_rep[4];
        logic ren;

        // {btn, repeat_en, debounced, press, release, repeat, action}
        vecs = '{
            7'b1_0_0_0_0_0_0, 7'b1_0_0_0_0_0_0, 7'b1_0_0_0_0_0_0,
            7'b1_0_0_0_0_0_0, 7'b1_0_0_0_0_0_0, 7'b1_0_0_0_0_0_0,
            7'b1_0_1_1_0_0_1,
            7'b1_0_1_0_0_0_0, 7'b1_0_1_0_0_0_0,
            7'b0_0_1_0_0_0_0, 7'b0_0_1_0_0_0_0, 7'b0_0_1_0_0_0_0,
            7'b0_0_1_0_0_0_0, 7'b0_0_1_0_0_0_0, 7'b0_0_1_0_0_0_0,
            7'b0_0_0_0_1_0_0,
            7'b0_0_0_0_0_0_0
        };

        model_reset();
        evt_cnt  = 8'd0;
        last_deb = 1'b0;
        clear_obs();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(outs), 32'h0);
        reset = 1'b0;
        run(1'b0, 1'b0, 5);

        // Clean press and release from the vector table
        for (int i = 0; i < 17; i++) begin
            cyc(vecs[i].btn, vecs[i].en);
            check($sformatf("table_row%0d", i), 32'(outs), 32'(vecs[i].exp));
        end
        run(1'b0, 1'b0, 3);

        // Bounce on press: only the stable run counts
        clear_obs();
        cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0); cyc(1'b0, 1'b0);
        start = cyc_n + 1;
        run(1'b1, 1'b0, 12);
        check("bounce_press_count", press_cnt, 1);
        check("bounce_press_edge", press_at, start + 6);
        check("bounce_deb_rise", deb_rise_at, start + 6);

        // Short low glitch while held, then a real release
        clear_obs();
        run(1'b0, 1'b0, 3);
        run(1'b1, 1'b0, 10);
        check("glitch_no_release", release_cnt, 0);
        check("glitch_deb_held", 32'(debounced), 32'h1);
        check("glitch_no_fall", deb_fall_at, -1);
        start = cyc_n + 1;
        run(1'b0, 1'b0, 10);
        check("release_count", release_cnt, 1);
        check("release_edge", release_at, start + 6);
        check("release_deb_fall", deb_fall_at, start + 6);
        check("release_no_press", press_cnt, 0);

        // Auto-repeat over a 40-cycle hold
        clear_obs();
        start = cyc_n + 1;
        run(1'b1, 1'b1, 40);
        run(1'b0, 1'b1, 12);
        check("rep_press_edge", press_at, start + 6);
        check("rep_count", rep_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            got = (k < rep_q.size()) ? rep_q[k] : -1;
            check($sformatf("rep_edge%0d", k), got, start + 6 + 10 + 5 * k);
        end
        check("rep_release_edge", release_at, start + 46);

        // Dropping repeat_en mid-hold restarts the hold delay
        clear_obs();
        run(1'b1, 1'b1, 7);
        p2 = cyc_n;
        check("en_press_edge", press_at, p2);
        run(1'b1, 1'b1, 12);
        run(1'b1, 1'b0, 7);
        run(1'b1, 1'b1, 20);
        run(1'b0, 1'b1, 12);
        exp_rep = '{10, 29, 34, 39};
        check("en_rep_count", rep_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            got = (k < rep_q.size()) ? rep_q[k] : -1;
            check($sformatf("en_rep_edge%0d", k), got, p2 + exp_rep[k]);
        end

        // Reset while waiting for a press, then while held
        run(1'b0, 1'b0, 4);
        run(1'b1, 1'b0, 3);
        do_reset(2);
        clear_obs();
        base = cyc_n;
        run(1'b1, 1'b0, 10);
        check("rst_wait_press_count", press_cnt, 1);
        check("rst_wait_press_edge", press_at, base + 7);
        run(1'b1, 1'b1, 12);
        do_reset(1);
        clear_obs();
        base = cyc_n;
        run(1'b1, 1'b0, 8);
        check("rst_held_press_edge", press_at, base + 7);
        run(1'b0, 1'b0, 10);

        // Downstream mod-256 event counter fed by action_pulse
        e0 = 32'(evt_cnt);
        for (int k = 0; k < 3; k++) begin
            run(1'b1, 1'b0, 10);
            run(1'b0, 1'b0, 10);
        end
        check("counter_presses", 32'(8'(evt_cnt - 8'(e0))), 3);
        e0 = 32'(evt_cnt);
        run(1'b1, 1'b1, 40);
        run(1'b0, 1'b1, 12);
        check("counter_repeats", 32'(8'(evt_cnt - 8'(e0))), 7);

        // Randomized segments against the reference model
        ren = 1'b1;
        for (int seg = 0; seg < 200; seg++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 7));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 15) == 0) ren = ~ren;
                cyc(lvl, ren);
            end
            if ($urandom_range(0, 49) == 0) do_reset(int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
